// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // One extra bit so a count of WIDTH-1 fits even when WIDTH is a power of two or 1.
    function automatic int CNT_W(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/serial_sub_fs_bit.sv
// Combinational 1-bit full subtractor (a - b - c) built from NOR gates only.
module fs_bit (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic diff,
    output logic bo
);
    logic n1, n2, n3, ab_xnor, ab_xor, nc, and_t, or_n;
    logic m1, m2, m3;

    // a XNOR b; n2 doubles as (~a & b) for the borrow term.
    assign n1      = ~(a | b);
    assign n2      = ~(a | n1);
    assign n3      = ~(b | n1);
    assign ab_xnor = ~(n2 | n3);
    assign ab_xor  = ~(ab_xnor | ab_xnor);

    // diff = (a^b)^c = XNOR(ab_xnor, c)
    assign m1   = ~(ab_xnor | c);
    assign m2   = ~(ab_xnor | m1);
    assign m3   = ~(c | m1);
    assign diff = ~(m2 | m3);

    // bo = (~a & b) | (ab_xnor & c)
    assign nc    = ~(c | c);
    assign and_t = ~(ab_xor | nc);
    assign or_n  = ~(n2 | and_t);
    assign bo    = ~(or_n | or_n);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor with start/done handshake, LSB first.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);
    localparam int unsigned CW = CNT_W(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh, b_sh, diff_sh, diff_sh_nxt, diff_q;
    logic             brw, bout_q, d_bit, bo_bit, accept, last;
    logic [CW-1:0]    cnt;

    fs_bit u_fs_bit (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .c    (brw),
        .diff (d_bit),
        .bo   (bo_bit)
    );

    assign accept = start && (state_q == IDLE || state_q == DONE);
    assign last   = (cnt == CW'(WIDTH - 1));

    generate
        if (WIDTH == 1) begin : g_w1
            assign diff_sh_nxt = d_bit;
        end else begin : g_wn
            assign diff_sh_nxt = {d_bit, diff_sh[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (last) state_d = DONE;
            DONE:    state_d = start ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == SHIFT);
        done = (state_q == DONE);
        diff = diff_q;
        bout = bout_q;
    end

    // Result registers load on the SHIFT->DONE edge and then hold until the next result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            diff_sh <= '0;
            brw     <= 1'b0;
            cnt     <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else if (accept) begin
            a_sh    <= a;
            b_sh    <= b;
            brw     <= bin;
            cnt     <= '0;
            diff_sh <= '0;
        end else if (state_q == SHIFT) begin
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            brw     <= bo_bit;
            diff_sh <= diff_sh_nxt;
            cnt     <= cnt + CW'(1);
            if (last) begin
                diff_q <= diff_sh_nxt;
                bout_q <= bo_bit;
            end
        end
    end

endmodule
